// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: combinational reads, byte-lane writes, post-reset clear engine.
// Optional per-byte parity checking is enabled by defining DMEM_PARITY_EN.
module mips_dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [29:0] BASE_WADDR = 30'h04000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [29:0]           mem_addr,
    input  logic [31:0]           mem_data_in,
    input  logic [3:0]            mem_write_en,
    output logic [31:0]           mem_data_out,
    output logic                  mem_excpt,
    output logic                  ready,
    output logic [DEPTH_LOG2-1:0] clear_idx
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [29:0]           DEPTH_W  = 30'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [DEPTH_LOG2-1:0]   idx_nx;
    logic [31:0]             mem [DEPTH];
    logic [29:0]             offset;
    logic                    in_window;
    logic [DEPTH_LOG2-1:0]   index;
    logic [31:0]             rd_word;
    logic                    wr_any;
    logic                    parity_err;

    // Offset wraps modulo 2^30, so addresses below the base land far out of window.
    assign offset    = mem_addr - BASE_WADDR;
    assign in_window = (offset < DEPTH_W);
    assign index     = offset[DEPTH_LOG2-1:0];
    assign rd_word   = mem[index];
    assign wr_any    = |mem_write_en;

`ifdef DMEM_PARITY_EN
    logic [3:0] par [DEPTH];
    logic [3:0] rd_par;

    assign rd_par     = {^rd_word[31:24], ^rd_word[23:16], ^rd_word[15:8], ^rd_word[7:0]};
    assign parity_err = (state == S_RUN) && in_window && !wr_any && (rd_par != par[index]);
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= state_nx;
            clear_idx <= idx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = clear_idx;
        mem_excpt    = 1'b0;
        mem_data_out = rd_word;
        ready        = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_excpt = wr_any;
                idx_nx    = clear_idx + DEPTH_LOG2'(1);
                if (clear_idx == LAST_IDX) state_nx = S_RUN;
            end
            S_RUN: begin
                ready     = 1'b1;
                mem_excpt = !in_window || parity_err;
                if (!in_window) mem_data_out = '0;
                if (parity_err) state_nx = S_ERR;
            end
            S_ERR: begin
                ready        = 1'b1;
                mem_excpt    = 1'b1;
                mem_data_out = '0;
            end
            default: begin
                state_nx     = S_CLEAR;
                idx_nx       = '0;
                mem_excpt    = 1'b1;
                mem_data_out = '0;
            end
        endcase
    end

    // Reset discards any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clear_idx] <= '0;
`ifdef DMEM_PARITY_EN
                par[clear_idx] <= '0;
`endif
            end else if (state == S_RUN && wr_any && in_window) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_write_en[b]) begin
                        mem[index][8*b +: 8] <= mem_data_in[8*b +: 8];
`ifdef DMEM_PARITY_EN
                        par[index][b] <= ^mem_data_in[8*b +: 8];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: driver pushes expected responses from a word-array model,
// a negedge monitor pops and compares.
module tb_mips_dmem_responder;

  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
  localparam logic [29:0] BASE  = 30'h04000000;
  localparam int          W     = 39;

  logic        clk;
  logic        rst;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_data_out;
  logic        mem_excpt;
  logic        ready;
  logic [DL-1:0] clear_idx;

  mips_dmem_responder #(.DEPTH_LOG2(DL), .BASE_WADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .mem_excpt(mem_excpt),
    .ready(ready),
    .clear_idx(clear_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] model_mem [DEPTH];
  logic [3:0]  bad_lanes [DEPTH];
  int          clr_cnt;
  bit          model_valid;
  bit          model_err;

  // scoreboard: {check_data, data, excpt, ready, clear_idx}
  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("excpt", 32'(mem_excpt), 32'(e[5]));
      chk("ready", 32'(ready), 32'(e[4]));
      chk("clear_idx", 32'(clear_idx), 32'(e[3:0]));
      if (e[38]) chk("data_out", mem_data_out, e[37:6]);
    end
  end

  // driver: called at posedge+1, drives one cycle, pushes expectation, advances model past the edge
  task automatic step(input logic [29:0] a, input logic [31:0] d, input logic [3:0] we, input logic r);
    logic [29:0] off;
    logic [3:0]  wi;
    bit          inwin;
    bit          perr;
    logic [31:0] ed;
    bit          ex;
    bit          rdy;
    logic [3:0]  ei;
    bit          cd;
    mem_addr     = a;
    mem_data_in  = d;
    mem_write_en = we;
    rst          = r;
    off   = a - BASE;
    inwin = (off < 30'(DEPTH));
    wi    = off[3:0];
    perr  = 1'b0;
    if (model_valid) begin
      if (clr_cnt < DEPTH) begin
        rdy = 1'b0; ei = 4'(clr_cnt); ex = (we != 4'h0); cd = 1'b0; ed = '0;
      end else if (model_err) begin
        rdy = 1'b1; ei = 4'h0; ex = 1'b1; cd = 1'b1; ed = '0;
      end else begin
        rdy  = 1'b1; ei = 4'h0; cd = 1'b1;
        perr = inwin && (we == 4'h0) && (bad_lanes[wi] != 4'h0);
        ex   = !inwin || perr;
        ed   = inwin ? model_mem[wi] : 32'h0;
      end
      exp_q.push_back({cd, ed, ex, rdy, ei});
    end
    @(posedge clk);
    if (r) begin
      clr_cnt     = 0;
      model_err   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (clr_cnt < DEPTH) begin
        model_mem[clr_cnt] = '0;
        bad_lanes[clr_cnt] = '0;
        clr_cnt++;
      end else if (!model_err) begin
        if (perr) model_err = 1'b1;
        else if (inwin && we != 4'h0) begin
          for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
              model_mem[wi][8*b +: 8] = d[8*b +: 8];
              bad_lanes[wi][b] = 1'b0;
            end
          end
        end
      end
    end
    #1;
  endtask

  function automatic logic [29:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 30'd1;
      1:       return BASE + 30'd16;
      2:       return 30'($urandom);
      default: return BASE + 30'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] rand_we();
    if ($urandom_range(0, 2) == 0) return 4'($urandom_range(1, 15));
    return 4'h0;
  endfunction

  task automatic clear_run();
    for (int i = 0; i < DEPTH; i++) step(rand_addr(), $urandom, rand_we(), 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(BASE + 30'(i), 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_valid = 1'b0;
    model_err = 1'b0;
    clr_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      bad_lanes[i] = '0;
    end
    rst = 1'b1;
    mem_addr = '0;
    mem_data_in = '0;
    mem_write_en = '0;
    @(posedge clk);
    #1;
    step(30'h0, 32'h0, 4'h0, 1'b1);

    // initial reset + clear, with stray writes during clear, then every word must be zero
    step(BASE, 32'h0, 4'h0, 1'b1);
    clear_run();
    read_all();

    // byte lanes, including same-cycle read-old / next-cycle read-new
    step(BASE + 30'd3, 32'hAABBCCDD, 4'hF, 1'b0);
    step(BASE + 30'd3, 32'h11223344, 4'b0101, 1'b0);
    step(BASE + 30'd3, 32'h0, 4'h0, 1'b0);

    // window edges and an out-of-window write
    step(BASE - 30'd1, 32'h0, 4'h0, 1'b0);
    step(BASE + 30'd16, 32'h0, 4'h0, 1'b0);
    step(BASE + 30'd16, 32'hFFFFFFFF, 4'hF, 1'b0);
    step(30'h3FFFFFFF, 32'hFFFFFFFF, 4'hF, 1'b0);
    read_all();

    // reset mid-run, then reset mid-clear at clear_idx 7
    step(BASE, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 7; i++) step(rand_addr(), $urandom, rand_we(), 1'b0);
    step(BASE + 30'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    clear_run();
    read_all();

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(rand_addr(), $urandom, rand_we(), ($urandom_range(0, 99) == 0));
    step(BASE, 32'h0, 4'h0, 1'b1);
    clear_run();
    read_all();

`ifdef DMEM_PARITY_EN
    step(BASE + 30'd2, 32'h12345678, 4'hF, 1'b0);
    dut.mem[2][5] = ~dut.mem[2][5];
    model_mem[2] = model_mem[2] ^ 32'h20;
    bad_lanes[2][0] = 1'b1;
    step(BASE + 30'd2, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(rand_addr(), $urandom, rand_we(), 1'b0);
    step(BASE, 32'h0, 4'h0, 1'b1);
    clear_run();
    read_all();
`endif

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
